// File: rtl/alu_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_arb_pkg : shared types for the two-port ALU arbiter (opcodes, FSM, helpers)
// Revision    : 1.0  initial release
// ---------------------------------------------------------------------------
package alu_arb_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0110,
        OP_SLT = 4'b0111,
        OP_MUL = 4'b1100
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    // Requester index to its one-hot position in the handshake vectors.
    function automatic logic [NUM_REQ-1:0] onehot_req(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_share_arb_alu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ALU      : combinational ALU; unknown opcodes give result 0 / zero 1
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module ALU
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [3:0]       ctrl_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o
);

    always_comb begin
        result_o = '0;
        case (ctrl_i)
            OP_AND:  result_o = src1_i & src2_i;
            OP_OR:   result_o = src1_i | src2_i;
            OP_ADD:  result_o = src1_i + src2_i;
            OP_SUB:  result_o = src1_i - src2_i;
            OP_SLT:  result_o = {{(WIDTH-1){1'b0}}, (src1_i < src2_i)};
            OP_MUL:  result_o = src1_i * src2_i;
            default: result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule
`default_nettype wire

// File: rtl/alu_share_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_share_arb : round-robin sharing of one ALU between two requesters
// Revision      : 1.0  initial release
// ---------------------------------------------------------------------------
module alu_share_arb
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NUM_REQ-1:0]                req_valid_i,
    output logic [NUM_REQ-1:0]                req_ready_o,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]     src1_i,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]     src2_i,
    input  logic [NUM_REQ-1:0][3:0]           ctrl_i,
    output logic [NUM_REQ-1:0]                resp_valid_o,
    input  logic [NUM_REQ-1:0]                resp_ready_i,
    output logic [WIDTH-1:0]                  result_o,
    output logic                              zero_o,
    output logic                              busy_o,
    output logic [NUM_REQ-1:0][CNT_W-1:0]     done_cnt_o
);

    arb_state_e       r_state;
    logic             r_prio;
    logic             r_owner;
    logic [WIDTH-1:0] r_src1;
    logic [WIDTH-1:0] r_src2;
    logic [3:0]       r_ctrl;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;

    logic             w_win;
    logic             w_accept;
    logic             w_resp_done;
    logic [WIDTH-1:0] w_alu_result;
    logic             w_alu_zero;

    // A lone requester always wins; the pointer only breaks ties.
    always_comb begin
        w_win = r_prio;
        case (req_valid_i)
            2'b01:   w_win = 1'b0;
            2'b10:   w_win = 1'b1;
            default: w_win = r_prio;
        endcase
    end

    assign w_accept     = (r_state == IDLE) && (|req_valid_i);
    assign req_ready_o  = w_accept ? onehot_req(w_win) : '0;
    assign resp_valid_o = (r_state == RESP) ? onehot_req(r_owner) : '0;
    assign w_resp_done  = (r_state == RESP) && resp_ready_i[r_owner];

    assign busy_o   = (r_state != IDLE);
    assign result_o = r_result;
    assign zero_o   = r_zero;

    ALU #(
        .WIDTH    (WIDTH)
    ) u_alu (
        .src1_i   (r_src1),
        .src2_i   (r_src2),
        .ctrl_i   (r_ctrl),
        .result_o (w_alu_result),
        .zero_o   (w_alu_zero)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_prio   <= 1'b0;
            r_owner  <= 1'b0;
            r_src1   <= '0;
            r_src2   <= '0;
            r_ctrl   <= '0;
            r_result <= '0;
            r_zero   <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_owner <= w_win;
                        r_src1  <= src1_i[w_win];
                        r_src2  <= src2_i[w_win];
                        r_ctrl  <= ctrl_i[w_win];
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_result <= w_alu_result;
                    r_zero   <= w_alu_zero;
                    r_state  <= RESP;
                end
                RESP: begin
                    // The requester that lost this grant gets the next tie.
                    if (w_resp_done) begin
                        r_prio  <= ~r_owner;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    generate
        for (genvar k = 0; k < NUM_REQ; k++) begin : g_cnt
            logic [CNT_W-1:0] r_cnt;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_cnt <= '0;
                end else if (resp_valid_o[k] && resp_ready_i[k]) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end

            assign done_cnt_o[k] = r_cnt;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_alu_share_arb : directed scenarios plus randomized traffic vs a txn model
// Revision         : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_alu_share_arb;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [1:0]               req_valid;
    logic [1:0]               req_ready;
    logic [1:0][WIDTH-1:0]    src1;
    logic [1:0][WIDTH-1:0]    src2;
    logic [1:0][3:0]          ctrl;
    logic [1:0]               resp_valid;
    logic [1:0]               resp_ready;
    logic [WIDTH-1:0]         result;
    logic                     zero;
    logic                     busy;
    logic [1:0][CNT_W-1:0]    done_cnt;

    int checks = 0;
    int errors = 0;

    logic             m_prio;
    logic [CNT_W-1:0] m_cnt [2];
    logic [3:0]       ops [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110,
                                  4'b0111, 4'b1100, 4'b1111, 4'b0011};

    alu_share_arb #(
        .WIDTH        (WIDTH),
        .CNT_W        (CNT_W)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .src1_i       (src1),
        .src2_i       (src2),
        .ctrl_i       (ctrl),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .result_o     (result),
        .zero_o       (zero),
        .busy_o       (busy),
        .done_cnt_o   (done_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    function automatic logic [WIDTH-1:0] alu_ref(input logic [3:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [63:0] p;
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return (a < b) ? 32'd1 : 32'd0;
            4'b1100: begin
                p = 64'(a) * 64'(b);
                return p[31:0];
            end
            default: return '0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        resp_ready = '0;
        step();
        step();
        rst = 1'b0;
        m_prio = 1'b0;
        m_cnt[0] = '0;
        m_cnt[1] = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '0;
        resp_ready = '0;
        src1 = '0; src2 = '0; ctrl = '0;
        step();
        step();
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b exp 00", req_ready); end
        checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL reset_resp_valid got %b exp 00", resp_valid); end
        checks++; if (result !== '0) begin errors++; $display("FAIL reset_result got %0h exp 0", result); end
        checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero got %b exp 1", zero); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done_cnt !== '0) begin errors++; $display("FAIL reset_done_cnt got %h exp 0", done_cnt); end
        rst = 1'b0;
        m_prio = 1'b0;
        m_cnt[0] = '0;
        m_cnt[1] = '0;
    endtask

    task automatic test_single();
        req_valid = 2'b01; src1[0] = 5; src2[0] = 7; ctrl[0] = 4'b0010; resp_ready = '0;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_req_ready got %b exp 01", req_ready); end
        step();
        req_valid = '0;
        #1;
        checks++; if (busy !== 1'b1 || resp_valid !== 2'b00) begin errors++; $display("FAIL single_exec got busy %b rv %b exp 1 00", busy, resp_valid); end
        step();
        checks++; if (resp_valid !== 2'b01) begin errors++; $display("FAIL single_resp_valid got %b exp 01", resp_valid); end
        checks++; if (result !== 32'd12 || zero !== 1'b0) begin errors++; $display("FAIL single_result got %0d/%b exp 12/0", result, zero); end
        resp_ready = 2'b01;
        step();
        resp_ready = '0;
        m_cnt[0] = m_cnt[0] + 1'b1; m_prio = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || done_cnt[0] !== m_cnt[0]) begin errors++; $display("FAIL single_done got busy %b cnt %0d exp 0 %0d", busy, done_cnt[0], m_cnt[0]); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        req_valid = 2'b11; resp_ready = 2'b11;
        src1[0] = 3; src2[0] = 3; ctrl[0] = 4'b0110;
        src1[1] = 32'h10000; src2[1] = 32'h10000; ctrl[1] = 4'b1100;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL simul_first_grant got %b exp 01", req_ready); end
        step(); req_valid = 2'b10;
        step();
        checks++; if (resp_valid !== 2'b01 || result !== '0 || zero !== 1'b1) begin errors++; $display("FAIL simul_r0_resp got %b %0h %b exp 01 0 1", resp_valid, result, zero); end
        step();
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL simul_second_grant got %b exp 10", req_ready); end
        step(); req_valid = 2'b00;
        step();
        checks++; if (resp_valid !== 2'b10 || result !== '0 || zero !== 1'b1) begin errors++; $display("FAIL simul_r1_resp got %b %0h %b exp 10 0 1", resp_valid, result, zero); end
        step();
        req_valid = 2'b11;
        src1[0] = 1; src2[0] = 2; ctrl[0] = 4'b0010;
        src1[1] = 4; src2[1] = 8; ctrl[1] = 4'b0001;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL simul_alt_r0 got %b exp 01", req_ready); end
        step(); req_valid = 2'b10;
        step();
        checks++; if (result !== 32'd3) begin errors++; $display("FAIL simul_alt_r0_result got %0d exp 3", result); end
        step();
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL simul_alt_r1 got %b exp 10", req_ready); end
        step(); req_valid = 2'b00;
        step();
        checks++; if (result !== 32'd12) begin errors++; $display("FAIL simul_alt_r1_result got %0d exp 12", result); end
        step();
        resp_ready = '0;
        m_cnt[0] = m_cnt[0] + 2'd2; m_cnt[1] = m_cnt[1] + 2'd2; m_prio = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done_cnt[0] !== m_cnt[0] || done_cnt[1] !== m_cnt[1]) begin errors++; $display("FAIL simul_counts got %b %0d %0d exp 0 %0d %0d", busy, done_cnt[0], done_cnt[1], m_cnt[0], m_cnt[1]); end
    endtask

    task automatic test_backpressure();
        req_valid = 2'b10; resp_ready = '0;
        src1[1] = 2; src2[1] = 9; ctrl[1] = 4'b0111;
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_grant got %b exp 10", req_ready); end
        step();
        req_valid = 2'b01; src1[0] = 32'hF0; src2[0] = 32'h3C; ctrl[0] = 4'b0000;
        #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_exec_ready got %b exp 00", req_ready); end
        step();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (resp_valid !== 2'b10 || result !== 32'd1 || req_ready !== 2'b00) begin
                errors++; $display("FAIL bp_hold[%0d] got rv %b res %0d rdy %b exp 10 1 00", i, resp_valid, result, req_ready);
            end
            step();
        end
        resp_ready = 2'b10;
        #1;
        checks++; if (req_ready !== 2'b00 || resp_valid !== 2'b10) begin errors++; $display("FAIL bp_handshake_cycle got rdy %b rv %b exp 00 10", req_ready, resp_valid); end
        step();
        resp_ready = '0;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_after_handshake got %b exp 01", req_ready); end
        step(); req_valid = '0;
        step();
        checks++; if (resp_valid !== 2'b01 || result !== 32'h30) begin errors++; $display("FAIL bp_r0_result got %b %0h exp 01 30", resp_valid, result); end
        resp_ready = 2'b01;
        step();
        resp_ready = '0;
        m_cnt[0] = m_cnt[0] + 1'b1; m_cnt[1] = m_cnt[1] + 1'b1; m_prio = 1'b1;
        checks++; if (done_cnt[0] !== m_cnt[0] || done_cnt[1] !== m_cnt[1]) begin errors++; $display("FAIL bp_counts got %0d %0d exp %0d %0d", done_cnt[0], done_cnt[1], m_cnt[0], m_cnt[1]); end
    endtask

    task automatic test_illegal();
        req_valid = 2'b10; src1[1] = 32'h1234; src2[1] = 32'h55; ctrl[1] = 4'b1111; resp_ready = '0;
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL illegal_grant got %b exp 10", req_ready); end
        step(); req_valid = '0;
        step();
        checks++; if (resp_valid !== 2'b10 || result !== '0 || zero !== 1'b1) begin errors++; $display("FAIL illegal_result got %b %0h %b exp 10 0 1", resp_valid, result, zero); end
        resp_ready = 2'b01;
        step();
        checks++; if (resp_valid !== 2'b10 || busy !== 1'b1 || done_cnt[1] !== m_cnt[1]) begin errors++; $display("FAIL wrong_bit_ready got rv %b busy %b cnt %0d exp 10 1 %0d", resp_valid, busy, done_cnt[1], m_cnt[1]); end
        resp_ready = 2'b10;
        step();
        resp_ready = '0;
        m_cnt[1] = m_cnt[1] + 1'b1; m_prio = 1'b0;
        checks++; if (busy !== 1'b0 || done_cnt[1] !== m_cnt[1]) begin errors++; $display("FAIL illegal_done got busy %b cnt %0d exp 0 %0d", busy, done_cnt[1], m_cnt[1]); end
    endtask

    task automatic test_reset_resp();
        req_valid = 2'b01; src1[0] = 1; src2[0] = 1; ctrl[0] = 4'b0010; resp_ready = 2'b01;
        step(); req_valid = '0;
        step();
        checks++; if (result !== 32'd2) begin errors++; $display("FAIL rstresp_pre_result got %0d exp 2", result); end
        step();
        resp_ready = '0;
        req_valid = 2'b01;
        step(); req_valid = '0;
        step();
        checks++; if (resp_valid !== 2'b01) begin errors++; $display("FAIL rstresp_in_resp got %b exp 01", resp_valid); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_prio = 1'b0; m_cnt[0] = '0; m_cnt[1] = '0;
        checks++; if (resp_valid !== 2'b00 || busy !== 1'b0 || done_cnt !== '0) begin errors++; $display("FAIL rstresp_after got rv %b busy %b cnt %h exp 00 0 0", resp_valid, busy, done_cnt); end
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rstresp_prio got %b exp 01", req_ready); end
        step(); req_valid = '0; resp_ready = 2'b11;
        step();
        step();
        resp_ready = '0;
        m_cnt[0] = m_cnt[0] + 1'b1; m_prio = 1'b1;
    endtask

    task automatic test_wrap();
        logic [WIDTH-1:0] a, b, exp;
        logic [3:0]       op;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            op = ops[$urandom_range(0, 7)];
            a = $urandom; b = $urandom_range(0, 1) ? $urandom : a;
            req_valid = 2'b10; src1[1] = a; src2[1] = b; ctrl[1] = op;
            exp = alu_ref(op, a, b);
            #1;
            checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL wrap_grant[%0d] got %b exp 10", i, req_ready); end
            step(); req_valid = '0;
            step();
            checks++; if (resp_valid !== 2'b10 || result !== exp || zero !== (exp == '0)) begin errors++; $display("FAIL wrap_result[%0d] op %b got %0h %b exp %0h", i, op, result, zero, exp); end
            resp_ready = 2'b10;
            step();
            resp_ready = '0;
            m_cnt[1] = m_cnt[1] + 1'b1; m_prio = 1'b0;
            checks++; if (done_cnt[1] !== m_cnt[1] || done_cnt[0] !== m_cnt[0]) begin errors++; $display("FAIL wrap_cnt[%0d] got %0d %0d exp %0d %0d", i, done_cnt[1], done_cnt[0], m_cnt[1], m_cnt[0]); end
        end
        checks++; if (done_cnt[1] !== 4'd0 || done_cnt[0] !== 4'd0) begin errors++; $display("FAIL wrap_final got %0d %0d exp 0 0", done_cnt[1], done_cnt[0]); end
    endtask

    task automatic test_random();
        logic [1:0]       pend, exp_rdy, exp_rv;
        logic [3:0]       p_op [2];
        logic [WIDTH-1:0] p_a [2];
        logic [WIDTH-1:0] p_b [2];
        logic             inflight, owner;
        logic [WIDTH-1:0] exp_res;
        int               acc;
        do_reset();
        pend = '0; inflight = 1'b0; owner = 1'b0; exp_res = '0; acc = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int k = 0; k < 2; k++) begin
                if (!pend[k] && $urandom_range(0, 2) == 0) begin
                    pend[k] = 1'b1;
                    p_op[k] = ops[$urandom_range(0, 7)];
                    p_a[k]  = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 15);
                    p_b[k]  = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 15);
                end
                src1[k] = p_a[k]; src2[k] = p_b[k]; ctrl[k] = p_op[k];
            end
            req_valid  = pend;
            resp_ready = 2'($urandom_range(0, 3));
            #1;
            exp_rdy = 2'b00;
            if (!inflight) begin
                if (pend == 2'b01)      exp_rdy = 2'b01;
                else if (pend == 2'b10) exp_rdy = 2'b10;
                else if (pend == 2'b11) exp_rdy = m_prio ? 2'b10 : 2'b01;
            end
            checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rand_ready[%0d] got %b exp %b", cyc, req_ready, exp_rdy); end
            exp_rv = (inflight && cyc >= acc + 2) ? (owner ? 2'b10 : 2'b01) : 2'b00;
            checks++; if (resp_valid !== exp_rv) begin errors++; $display("FAIL rand_resp_valid[%0d] got %b exp %b", cyc, resp_valid, exp_rv); end
            if (exp_rv != 2'b00) begin
                checks++; if (result !== exp_res || zero !== (exp_res == '0)) begin errors++; $display("FAIL rand_result[%0d] got %0h %b exp %0h", cyc, result, zero, exp_res); end
            end
            checks++; if (done_cnt[0] !== m_cnt[0] || done_cnt[1] !== m_cnt[1]) begin errors++; $display("FAIL rand_cnt[%0d] got %0d %0d exp %0d %0d", cyc, done_cnt[0], done_cnt[1], m_cnt[0], m_cnt[1]); end
            if (exp_rdy != 2'b00) begin
                inflight = 1'b1;
                owner    = exp_rdy[1];
                exp_res  = alu_ref(p_op[owner], p_a[owner], p_b[owner]);
                acc      = cyc;
                pend[owner] = 1'b0;
            end else if (exp_rv != 2'b00 && resp_ready[owner]) begin
                m_cnt[owner] = m_cnt[owner] + 1'b1;
                m_prio       = ~owner;
                inflight     = 1'b0;
            end
            step();
        end
        req_valid = '0; resp_ready = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_backpressure();
        test_illegal();
        test_reset_resp();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_share_arb.md
# alu_share_arb

Two-port arbiter and sequencer that shares one ALU between two independent requesters, e.g. the main datapath and an address/debug unit. Each requester issues operand/opcode transactions over a valid/ready handshake. The block grants them round-robin, registers operands, runs the ALU and holds the result until the owning requester accepts it. Exactly one transaction is in flight at a time.

## Interface
Parameters:
- `WIDTH`, default 32: operand/result width.
- `CNT_W`, default 16: width of the per-requester completion counters.

Ports (clock and reset first):
- `clk_i`  in  1: clock, rising edge.
- `rst_i`  in  1: reset, synchronous, active-high.
- `req_valid_i`  in  2: request valid, bit k = requester k.
- `req_ready_o`  out  2: request accepted this cycle, one-hot or zero.
- `src1_i`  in  2x`WIDTH`: operand A per requester.
- `src2_i`  in  2x`WIDTH`: operand B per requester.
- `ctrl_i`  in  2x4: ALU opcode per requester.
- `resp_valid_o`  out  2: result valid for requester k, one-hot or zero.
- `resp_ready_i`  in  2: requester k accepts the result.
- `result_o`  out  `WIDTH`: result of the in-flight transaction.
- `zero_o`  out  1: `result_o` == 0.
- `busy_o`  out  1: state != IDLE.
- `done_cnt_o`  out  2x`CNT_W`: completed transactions per requester.

## Operation
- Opcodes:
  - 0000 AND, 0001 OR, 0010 ADD (mod 2^WIDTH), 0110 SUB (mod 2^WIDTH).
  - 0111 SLT: unsigned compare, result 1 or 0.
  - 1100 MUL: low `WIDTH` bits of the product.
  - Any other opcode gives result 0 and zero 1. No error flag.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any `req_valid_i` bit is set, select the winner, assert `req_ready_o`[win] combinationally and latch src1/src2/ctrl/owner.
  - Then go to EXEC.
- Winner selection:
  - Only one requester valid: that requester wins.
  - Both valid: the requester named by the priority pointer `prio` wins.
- EXEC:
  - The ALU reads the latched operands.
  - `result_o`/`zero_o` are registered into the result register.
  - Then go to RESP.
- RESP:
  - `resp_valid_o`[owner] = 1; `result_o`/`zero_o` are held stable.
  - On `resp_ready_i`[owner]: increment `done_cnt_o`[owner] (wraps to 0 at max), set `prio` to the loser of the last grant, go to IDLE.
  - `resp_ready_i` on the non-owner bit is ignored.
- `prio` changes only on response completion. After a grant to k, the other requester has priority.
- `req_ready_o` is 0 in EXEC and RESP. Requests stay pending and must hold their payload while valid and not ready.

## Timing
- Reset values:
  - state IDLE, `prio` 0.
  - `req_ready_o` 0, `resp_valid_o` 0, `result_o` 0, `zero_o` 1, `busy_o` 0, `done_cnt_o` all 0.
- Reset mid-transaction (EXEC or RESP): the transaction is dropped with no response and no counter increment. The block returns to IDLE next cycle.
- Latency and throughput:
  - Request accepted at edge N gives `resp_valid_o` high from cycle N+2.
  - Minimum occupancy is 3 cycles per transaction: IDLE, EXEC, RESP with `resp_ready_i` already high.
  - The response handshake and a new acceptance never occur in the same cycle.
- `resp_valid_o` stays high until handshake; it never drops or changes owner while waiting.
- `busy_o` is registered-state derived and is high in EXEC and RESP.

## Structure
- Package `alu_arb_pkg`:
  - `alu_op_e` enum holding the six opcodes above.
  - `arb_state_e` enum {IDLE, EXEC, RESP}.
  - `localparam` `NUM_REQ` = 2.
- One sub-module: the team's existing combinational `ALU`, instantiated once and fed from the operand registers. Its `result_o`/`zero_o` are captured in EXEC.
- Arbitration, FSM and counters stay inline. No separate arbiter module.

## Test plan
- **Single request:** requester 0 sends ADD 5+7 at cycle 0. Expect `req_ready_o`=01 at cycle 0, `resp_valid_o`=01 at cycle 2, `result_o`=12, `zero_o`=0, `done_cnt_o`[0]=1 after handshake.
- **Simultaneous requests from reset:** both valid, r0 SUB 3-3, r1 MUL 0x10000×0x10000.
  - r0 is granted first, result 0 with `zero_o`=1.
  - r1 is granted next, result 0 (low 32 bits) with `zero_o`=1.
  - Then with both valid again, r0 wins, because the pointer alternates.
- **Backpressure:** `resp_ready_i`[1] held low 5 cycles after r1 SLT 2<9. `resp_valid_o`=10 and `result_o`=1 are held stable all 5 cycles. A concurrent r0 request sees `req_ready_o`[0]=0 until the cycle after the handshake.
- **Illegal opcode and wrong-bit ready:** opcode 1111 gives `result_o`=0, `zero_o`=1. `resp_ready_i`=01 asserted while the owner is r1 does not complete the transaction.
- **Reset in RESP:** `rst_i` is pulsed while `resp_valid_o`=01. Next cycle: `resp_valid_o`=0, `busy_o`=0, counters 0, `prio`=0.
- **Counter wrap:** with `CNT_W`=4, 16 r1 transactions bring `done_cnt_o`[1] to 0. `done_cnt_o`[0] is unchanged.
